// File: rtl/axi4_lite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_cmd_master
//  Purpose  : AXI4-Lite initiator. It turns a simple command stream into
//             single AXI4-Lite read or write transactions and returns one
//             response per command. Only one transaction is outstanding.
//  Ports    : aclk/aresetn   - clock, async active-low reset
//             cmd_*          - command stream in (valid/ready)
//             rsp_*          - response stream out (valid/ready)
//             m_aw*/m_w*/m_b* - AXI4-Lite write channels
//             m_ar*/m_r*     - AXI4-Lite read channels
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_cmd_master #(
    parameter int A = 16,   // address width in bits
    parameter int N = 4     // data bus width in bytes
) (
    input  logic             aclk,
    input  logic             aresetn,
    // command stream
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [A-1:0]     cmd_addr,
    input  logic [8*N-1:0]   cmd_wdata,
    input  logic [N-1:0]     cmd_wstrb,
    // response stream
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [8*N-1:0]   rsp_rdata,
    output logic [1:0]       rsp_resp,
    // AW channel
    output logic [A-1:0]     m_awaddr,
    output logic [2:0]       m_awprot,
    output logic             m_awvalid,
    input  logic             m_awready,
    // W channel
    output logic [8*N-1:0]   m_wdata,
    output logic [N-1:0]     m_wstrb,
    output logic             m_wvalid,
    input  logic             m_wready,
    // B channel
    input  logic [1:0]       m_bresp,
    input  logic             m_bvalid,
    output logic             m_bready,
    // AR channel
    output logic [A-1:0]     m_araddr,
    output logic [2:0]       m_arprot,
    output logic             m_arvalid,
    input  logic             m_arready,
    // R channel
    input  logic [8*N-1:0]   m_rdata,
    input  logic [1:0]       m_rresp,
    input  logic             m_rvalid,
    output logic             m_rready
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_WR_ADDR_DATA = 3'd1,
        S_WR_RESP      = 3'd2,
        S_RD_ADDR      = 3'd3,
        S_RD_DATA      = 3'd4,
        S_RSP          = 3'd5
    } state_t;

    state_t           state_q,     state_d;
    logic [A-1:0]     addr_q,      addr_d;
    logic [8*N-1:0]   wdata_q,     wdata_d;
    logic [N-1:0]     wstrb_q,     wstrb_d;
    logic             awvalid_q,   awvalid_d;
    logic             wvalid_q,    wvalid_d;
    logic             bready_q,    bready_d;
    logic             arvalid_q,   arvalid_d;
    logic             rready_q,    rready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_write_q, rsp_write_d;
    logic [8*N-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]       rsp_resp_q,  rsp_resp_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Every handshake output is a register, so no output valid/ready is a
    // combinational function of a slave input.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_WR_ADDR_DATA: begin
                // AW and W retire independently; B is only opened once the
                // next-state of both valids is low, so a same-cycle pair of
                // handshakes still enters WR_RESP one cycle later.
                if (awvalid_q && m_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_bresp;
                    state_d     = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (m_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_rdata;
                    rsp_resp_d  = m_rresp;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    assign m_awaddr  = addr_q;
    assign m_awprot  = 3'b000;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = addr_q;
    assign m_arprot  = 3'b000;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_lite_cmd_master
//  Purpose  : Self-checking bench for axi4_lite_cmd_master. A cycle-stepped
//             slave with programmable per-channel delays answers each
//             command; expected responses come from the command itself.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_cmd_master;

    localparam int A = 16;
    localparam int N = 4;
    localparam int D = 8 * N;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [A-1:0]  cmd_addr;
    logic [D-1:0]  cmd_wdata;
    logic [N-1:0]  cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [D-1:0]  rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [A-1:0]  m_awaddr, m_araddr;
    logic [2:0]    m_awprot, m_arprot;
    logic          m_awvalid, m_awready, m_wvalid, m_wready;
    logic [D-1:0]  m_wdata, m_rdata;
    logic [N-1:0]  m_wstrb;
    logic [1:0]    m_bresp, m_rresp;
    logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axi4_lite_cmd_master #(.A(A), .N(N)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_slave();
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    endtask

    // One command end to end. d_* are slave delays in cycles counted from the
    // first cycle the matching valid/ready is seen. stall = cycles rsp_ready is
    // held low once rsp_valid appears. exp_lat < 0 skips the latency check.
    // hold = leave cmd_valid high afterwards (back-to-back stream).
    task automatic run_cmd(input bit wr, input logic [A-1:0] addr,
                           input logic [D-1:0] wd, input logic [N-1:0] ws,
                           input int d_aw, input int d_w, input int d_b,
                           input int d_ar, input int d_r,
                           input logic [1:0] sresp, input logic [D-1:0] srdata,
                           input int stall, input int exp_lat, input bit hold);
        int cyc, aw_n, w_n, b_n, ar_n, r_n;
        int aw_wait, w_wait, b_wait, ar_wait, r_wait, stall_left;
        bit done, rsp_seen, hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_rsp;
        logic [D-1:0] exp_rdata;
        exp_rdata = wr ? '0 : srdata;
        cyc = 1; aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        stall_left = stall; done = 0; rsp_seen = 0;

        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        rsp_ready = 1'b0;
        step();

        while (!done && cyc < 300) begin
            checks++;
            if (cmd_ready !== 1'b0 || m_awprot !== 3'd0 || m_arprot !== 3'd0) begin
                errors++;
                $display("FAIL busy_ctrl cyc=%0d: cmd_ready=%b awprot=%0d arprot=%0d want 0/0/0",
                         cyc, cmd_ready, m_awprot, m_arprot);
            end
            if (m_awvalid) begin
                checks++;
                if (!wr || aw_n != 0 || m_awaddr !== addr) begin
                    errors++;
                    $display("FAIL aw_chan cyc=%0d: awaddr=%h aw_done=%0d wr=%0d want addr %h once",
                             cyc, m_awaddr, aw_n, wr, addr);
                end
            end
            if (m_wvalid) begin
                checks++;
                if (!wr || w_n != 0 || m_wdata !== wd || m_wstrb !== ws) begin
                    errors++;
                    $display("FAIL w_chan cyc=%0d: wdata=%h wstrb=%h w_done=%0d want %h/%h once",
                             cyc, m_wdata, m_wstrb, w_n, wd, ws);
                end
            end
            if (m_arvalid) begin
                checks++;
                if (wr || ar_n != 0 || m_araddr !== addr) begin
                    errors++;
                    $display("FAIL ar_chan cyc=%0d: araddr=%h ar_done=%0d wr=%0d want addr %h once",
                             cyc, m_araddr, ar_n, wr, addr);
                end
            end
            if (m_bready) begin
                checks++;
                if (!wr || aw_n != 1 || w_n != 1 || b_n != 0) begin
                    errors++;
                    $display("FAIL bready_order cyc=%0d: aw=%0d w=%0d b=%0d want 1/1/0 on write",
                             cyc, aw_n, w_n, b_n);
                end
            end
            if (m_rready) begin
                checks++;
                if (wr || ar_n != 1 || r_n != 0) begin
                    errors++;
                    $display("FAIL rready_order cyc=%0d: ar=%0d r=%0d want 1/0 on read", cyc, ar_n, r_n);
                end
            end

            if (rsp_valid) begin
                checks++;
                if ((wr ? b_n : r_n) != 1 || rsp_write !== wr || rsp_rdata !== exp_rdata
                    || rsp_resp !== sresp) begin
                    errors++;
                    $display("FAIL rsp_fields cyc=%0d: write=%b rdata=%h resp=%0d want %b/%h/%0d",
                             cyc, rsp_write, rsp_rdata, rsp_resp, wr, exp_rdata, sresp);
                end
                if (!rsp_seen) begin
                    rsp_seen = 1;
                    if (exp_lat >= 0) begin
                        checks++;
                        if (cyc != exp_lat) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles want %0d", cyc, exp_lat);
                        end
                    end
                end
                if (stall_left > 0) begin
                    rsp_ready = 1'b0; stall_left--;
                end else begin
                    rsp_ready = 1'b1;
                end
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end

            // Slave model: readies may be high with no valid present.
            m_awready = m_awvalid ? (aw_wait >= d_aw) : 1'($urandom_range(0, 1));
            m_wready  = m_wvalid  ? (w_wait  >= d_w)  : 1'($urandom_range(0, 1));
            m_arready = m_arvalid ? (ar_wait >= d_ar) : 1'($urandom_range(0, 1));
            m_bvalid  = m_bready && (b_wait >= d_b);
            m_rvalid  = m_rready && (r_wait >= d_r);
            m_bresp   = sresp;
            m_rresp   = sresp;
            m_rdata   = m_rvalid ? srdata : D'($urandom);

            hs_aw  = m_awvalid && m_awready;
            hs_w   = m_wvalid && m_wready;
            hs_b   = m_bvalid && m_bready;
            hs_ar  = m_arvalid && m_arready;
            hs_r   = m_rvalid && m_rready;
            hs_rsp = rsp_valid && rsp_ready;
            if (m_awvalid && !hs_aw) aw_wait++;
            if (m_wvalid && !hs_w)   w_wait++;
            if (m_bready && !hs_b)   b_wait++;
            if (m_arvalid && !hs_ar) ar_wait++;
            if (m_rready && !hs_r)   r_wait++;

            // Garbage on the command port while busy must be ignored.
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = A'($urandom);
            cmd_wdata = D'($urandom);
            cmd_wstrb = N'($urandom);

            step();
            cyc++;
            if (hs_aw) aw_n++;
            if (hs_w)  w_n++;
            if (hs_b)  b_n++;
            if (hs_ar) ar_n++;
            if (hs_r)  r_n++;
            if (hs_rsp) done = 1;
        end

        rsp_ready = 1'b0;
        clear_slave();
        cmd_valid = hold;
        if (!done) begin
            errors++; $display("FAIL timeout: no response consumed within 300 cycles");
        end
        checks++;
        if (wr ? (aw_n != 1 || w_n != 1 || b_n != 1 || ar_n != 0)
               : (ar_n != 1 || r_n != 1 || aw_n != 0 || w_n != 0)) begin
            errors++;
            $display("FAIL hs_counts: aw=%0d w=%0d b=%0d ar=%0d r=%0d wr=%0d",
                     aw_n, w_n, b_n, ar_n, r_n, wr);
        end
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_rsp: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        clear_slave();
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0
            || m_bready !== 1'b0 || m_arvalid !== 1'b0 || m_rready !== 1'b0
            || rsp_write !== 1'b0 || rsp_rdata !== '0 || rsp_resp !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: cmd_ready=%b rsp_valid=%b aw=%b w=%b b=%b ar=%b r=%b rsp=%b/%h/%0d",
                     cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                     rsp_write, rsp_rdata, rsp_resp);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_basic_write();
        run_cmd(1'b1, 16'h0004, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 2'b00, '0, 0, 3, 1'b0);
    endtask

    task automatic test_read_delay();
        run_cmd(1'b0, 16'h003C, '0, '0, 0, 0, 0, 4, 0, 2'b00, 32'hB16B00B5, 0, 7, 1'b0);
        run_cmd(1'b0, 16'h0010, '0, '0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFEF00D, 0, 3, 1'b0);
    endtask

    task automatic test_write_orders();
        run_cmd(1'b1, 16'h0020, 32'hA5A5A5A5, 4'h3, 0, 3, 0, 0, 0, 2'b00, '0, 0, 6, 1'b0);
        run_cmd(1'b1, 16'h0024, 32'h5A5A5A5A, 4'hC, 3, 0, 0, 0, 0, 2'b00, '0, 0, 6, 1'b0);
        run_cmd(1'b1, 16'h0028, 32'h0F0F0F0F, 4'h5, 2, 2, 1, 0, 0, 2'b10, '0, 0, 6, 1'b0);
    endtask

    task automatic test_decerr();
        logic [D-1:0] rd;
        rd = D'($urandom);
        run_cmd(1'b0, 16'h1000, '0, '0, 0, 0, 0, 1, 2, 2'b11, rd, 0, 6, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_cmd(i[0] == 1'b0, A'(16'h0100 + 4 * i), D'($urandom), 4'hF, 0, 0, 0, 0, 0,
                    2'b00, D'($urandom), 5, -1, i != 3);
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 2; s++) begin
            cmd_valid = 1'b1; cmd_write = (s == 0); cmd_addr = 16'h0040;
            cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
            step();
            cmd_valid = 1'b0;
            if (s == 0) begin
                m_awready = 1'b1; m_wready = 1'b1;
                step();
                m_awready = 1'b0; m_wready = 1'b0;
                step();
            end
            checks++;
            if ((s == 0 && m_bready !== 1'b1) || (s == 1 && m_arvalid !== 1'b1)) begin
                errors++;
                $display("FAIL mid_state s=%0d: bready=%b arvalid=%b want in-flight", s, m_bready, m_arvalid);
            end
            #2 aresetn = 1'b0;
            #1;
            checks++;
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || m_awvalid !== 1'b0 || m_wvalid !== 1'b0
                || m_bready !== 1'b0 || m_arvalid !== 1'b0 || m_rready !== 1'b0
                || rsp_write !== 1'b0 || rsp_rdata !== '0 || rsp_resp !== 2'b00) begin
                errors++;
                $display("FAIL async_reset s=%0d: cmd_ready=%b rsp_valid=%b aw=%b w=%b b=%b ar=%b r=%b",
                         s, cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready);
            end
            @(negedge aclk);
            aresetn = 1'b1;
            step();
            run_cmd(s == 1, 16'h0044, 32'h01020304, 4'h9, 0, 0, 0, 0, 0, 2'b00, 32'h11223344, 0, 3, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_cmd(1'($urandom_range(0, 1)), A'($urandom), D'($urandom), N'($urandom),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    2'($urandom_range(0, 3)), D'($urandom), int'($urandom_range(0, 4)), -1,
                    (i != 19) && ($urandom_range(0, 1) == 1));
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_read_delay();
        test_write_orders();
        test_decerr();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
